// File: rtl/sat_sum_tree.sv
`default_nettype none
// ============================================================================
//  Module   : sat_sum_tree
//  Purpose  : Pipelined N_IN-operand signed adder tree with selectable
//             saturating or wrapping WIDTH-bit result and overflow reporting.
//             Used to combine equalizer band outputs into one output sample.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1            clock, rising edge
//    rst          in   1            synchronous active-high reset
//    in_valid_i   in   1            operand vector valid this cycle
//    in_data_i    in   N_IN*WIDTH   operand k at [k*WIDTH +: WIDTH]
//    sat_en_i     in   1            1 = saturate, 0 = wrap (sampled with data)
//    ovf_clr_i    in   1            clears ovf_sticky_o
//    out_valid_o  out  1            out_data_o / ovf_o valid
//    out_data_o   out  WIDTH        result
//    ovf_o        out  1            result exceeded WIDTH-bit signed range
//    ovf_sticky_o out  1            set on any qualified overflow
// ============================================================================
module sat_sum_tree #(
  parameter int WIDTH  = 16,
  parameter int N_IN   = 4,
  parameter int LEVELS = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic [N_IN*WIDTH-1:0]   in_data_i,
  input  logic                    sat_en_i,
  input  logic                    ovf_clr_i,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    ovf_o,
  output logic                    ovf_sticky_o
);

  // Internal width is exact for a sum of up to 2^LEVELS operands.
  localparam int IW = WIDTH + LEVELS;

  // Number of nodes at tree level l (level 0 = the operands themselves).
  function automatic int node_cnt(input int l);
    return (N_IN + (1 << l) - 1) >> l;
  endfunction

  // Index of the first node of level l inside the flat node vector.
  function automatic int node_base(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += node_cnt(k);
    return s;
  endfunction

  localparam int TOTAL = node_base(LEVELS + 1);

  // Every node of every level, flattened: level 0 is the sign-extended
  // operands, higher levels are the outputs of the per-level registers.
  logic [IW-1:0]   w_all [TOTAL];

  // Valid and mode bits travel alongside the data; index 0 is the input.
  logic [LEVELS:1] vld_q;
  logic [LEVELS:1] sat_q;
  logic [LEVELS:0] w_vld;
  logic [LEVELS:0] w_sat;

  assign w_vld = {vld_q, in_valid_i};
  assign w_sat = {sat_q, sat_en_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= w_vld[LEVELS-1:0];
    end
    sat_q <= w_sat[LEVELS-1:0];
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_ext
    assign w_all[k] = {{LEVELS{in_data_i[k*WIDTH+WIDTH-1]}}, in_data_i[k*WIDTH +: WIDTH]};
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NP = node_cnt(l - 1);
    localparam int NC = node_cnt(l);
    localparam int BP = node_base(l - 1);
    localparam int BC = node_base(l);

    for (genvar j = 0; j < NC; j++) begin : g_node
      logic [IW-1:0] w_b;
      logic [IW-1:0] sum_q;

      // An unpaired last node at this level is carried up unchanged.
      if (2 * j + 1 < NP) begin : g_pair
        assign w_b = w_all[BP + 2*j + 1];
      end else begin : g_pass
        assign w_b = '0;
      end

      always_ff @(posedge clk) begin
        if (w_vld[l-1]) begin
          sum_q <= w_all[BP + 2*j] + w_b;
        end
      end

      assign w_all[BC + j] = sum_q;
    end
  end

  // Final range check: the sum fits in WIDTH bits exactly when the bits
  // from the WIDTH-1 position upward are all copies of the sign.
  logic [IW-1:0]    w_sum;
  logic [LEVELS:0]  w_top;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  assign w_sum = w_all[node_base(LEVELS)];
  assign w_top = w_sum[IW-1:WIDTH-1];
  assign w_ovf = ~((&w_top) | ~(|w_top));

  always_comb begin
    w_res = w_sum[WIDTH-1:0];
    if (w_sat[LEVELS] && w_ovf) begin
      w_res = w_sum[IW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             ovf_q;
  logic             sticky_q;
  logic             sticky_d;

  // An overflow wins over a clear both on the edge it is loaded and for the
  // whole cycle it is visible on the outputs, so a clear issued alongside a
  // reported overflow can never hide it.
  always_comb begin
    sticky_d = sticky_q & ~ovf_clr_i;
    if ((w_vld[LEVELS] && w_ovf) || (out_valid_q && ovf_q)) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= w_vld[LEVELS];
      if (w_vld[LEVELS]) begin
        out_data_q <= w_res;
        ovf_q      <= w_ovf;
      end
      sticky_q <= sticky_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign ovf_o        = ovf_q;
  assign ovf_sticky_o = sticky_q;

endmodule
`default_nettype wire
